// File: rtl/mem_access_unit.sv
// Load/store front end for a 32x32-bit data RAM: one request at a time,
// read-modify-write for sub-word stores, sign/zero-extended loads.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [4:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state_r;
  logic        ready_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [31:0] resp_rdata_r;
  logic        mem_ce_r;
  logic        mem_we_r;
  logic [4:0]  mem_addr_r;
  logic [31:0] wbuf_r;
  logic [1:0]  lane_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [31:0] wdata_r;

  function automatic logic req_is_err(input logic [1:0] size, input logic [31:0] addr);
    logic err;
    case (size)
      2'b00:   err = 1'b0;
      2'b01:   err = addr[0];
      2'b10:   err = (addr[1:0] != 2'b00);
      default: err = 1'b1;
    endcase
    return err | (addr[31:7] != 25'd0);
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00: r[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      2'b10:   r = wdata;
      default: r = old;
    endcase
    return r;
  endfunction

  // Control FSM; every output is a register updated on the transition into the state that needs it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      mem_ce_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 5'd0;
      wbuf_r       <= 32'h0000_0000;
      lane_r       <= 2'b00;
      size_r       <= 2'b00;
      unsigned_r   <= 1'b0;
      wdata_r      <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && ready_r) begin
            lane_r     <= req_addr[1:0];
            size_r     <= req_size;
            unsigned_r <= req_unsigned;
            wdata_r    <= req_wdata;
            ready_r    <= 1'b0;
            if (req_is_err(req_size, req_addr)) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
            end else begin
              mem_ce_r   <= 1'b1;
              mem_addr_r <= req_addr[6:2];
              if (!req_we) begin
                state_r <= RD;
              end else if (req_size == 2'b10) begin
                state_r  <= WR;
                mem_we_r <= 1'b1;
                wbuf_r   <= req_wdata;
              end else begin
                state_r <= RMW_RD;
              end
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        RD: begin
          state_r      <= RESP;
          resp_rdata_r <= load_extend(mem_rdata, size_r, lane_r, unsigned_r);
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
          mem_ce_r     <= 1'b0;
          mem_addr_r   <= 5'd0;
        end
        RMW_RD: begin
          state_r  <= WR;
          wbuf_r   <= store_merge(mem_rdata, wdata_r, size_r, lane_r);
          mem_we_r <= 1'b1;
        end
        WR: begin
          state_r      <= RESP;
          resp_rdata_r <= 32'h0000_0000;
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
          mem_ce_r     <= 1'b0;
          mem_we_r     <= 1'b0;
          mem_addr_r   <= 5'd0;
        end
        RESP: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          ready_r      <= 1'b1;
        end
        default: begin
          state_r      <= IDLE;
          ready_r      <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          mem_ce_r     <= 1'b0;
          mem_we_r     <= 1'b0;
          mem_addr_r   <= 5'd0;
        end
      endcase
    end
  end

  assign req_ready  = ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign mem_ce     = mem_ce_r;
  // Gating with rst_n keeps a reset landing on the WR edge from committing the write.
  assign mem_we     = mem_we_r & rst_n;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = (state_r == WR) ? wbuf_r : 32'h0000_0000;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 32x32 RAM; directed
// vectors push expected responses, an independent monitor pops and compares.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ce;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_ce(mem_ce),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:31];
  initial for (int i = 0; i < 32; i++) ram[i] = 32'h0;
  always @(posedge clk) if (mem_ce && mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = (mem_ce && !mem_we) ? ram[mem_addr] : 32'h0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0;
  int ce_cnt = 0;
  logic [4:0] we_addr = 5'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: pops one expectation per resp_valid pulse.
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt  = we_cnt + 1;
      we_addr = mem_addr;
    end
    if (mem_ce) ce_cnt = ce_cnt + 1;
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_cycle", cyc, e.due);
      end
    end
  end

  int acc_cyc;

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata, input int lat,
                       input logic push, input logic hold);
    int n;
    exp_t e;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (push) begin
      e.err = exp_err; e.rdata = exp_rdata; e.due = acc_cyc + lat - 1;
      sb_q.push_back(e);
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) check("resp_timeout", sb_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    check({tag, "_mem_ce"}, {31'd0, mem_ce}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, {27'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  int w0, c0, a_prev, a_cur;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("reset");

    // Word store then load
    w0 = we_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1'b1, 1'b0);
    drain();
    check("sw_we_cycles", we_cnt - w0, 32'd1);
    check("sw_we_addr", {27'd0, we_addr}, 32'd4);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1'b1, 1'b0);
    drain();

    // Byte read-modify-write
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'h0, 2, 1'b1, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, 1'b0, 32'h0, 3, 1'b1, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11AA3344, 2, 1'b1, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 1'b0, 32'hFFFFFFAA, 2, 1'b1, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 1'b0, 32'h000000AA, 2, 1'b1, 1'b0);
    drain();

    // Halfword
    issue(1'b1, 2'b10, 1'b0, 32'h04, 32'h00000000, 1'b0, 32'h0, 2, 1'b1, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 32'h06, 32'h00008001, 1'b0, 32'h0, 3, 1'b1, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0, 32'h80010000, 2, 1'b1, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, 1'b0, 32'hFFFF8001, 2, 1'b1, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h06, 32'h0, 1'b0, 32'h00008001, 2, 1'b1, 1'b0);
    drain();

    // Error cases never touch memory
    c0 = ce_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b1, 32'h0, 1, 1'b1, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 1'b1, 32'h0, 1, 1'b1, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678, 1'b1, 32'h0, 1, 1'b1, 1'b0);
    issue(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0, 1, 1'b1, 1'b0);
    drain();
    check("err_no_mem_ce", ce_cnt - c0, 32'd0);

    // Reset during WR of a sub-word store
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h55667788, 1'b0, 32'h0, 2, 1'b1, 1'b0);
    drain();
    issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h00000099, 1'b0, 32'h0, 3, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_wr", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("abort");
    repeat (4) @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'h55667788, 2, 1'b1, 1'b0);
    drain();

    // Back-to-back with req_valid held high
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11AA3344, 2, 1'b1, 1'b1);
    a_prev = acc_cyc;
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000055, 1'b0, 32'h0, 3, 1'b1, 1'b1);
    a_cur = acc_cyc;
    check("b2b_spacing_lw", a_cur - a_prev, 32'd3);
    a_prev = a_cur;
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11AA5544, 2, 1'b1, 1'b1);
    a_cur = acc_cyc;
    check("b2b_spacing_sb", a_cur - a_prev, 32'd4);
    a_prev = a_cur;
    issue(1'b1, 2'b00, 1'b0, 32'h23, 32'h00000066, 1'b0, 32'h0, 3, 1'b1, 1'b1);
    a_cur = acc_cyc;
    check("b2b_spacing_lw2", a_cur - a_prev, 32'd3);
    a_prev = a_cur;
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h66AA5544, 2, 1'b1, 1'b0);
    a_cur = acc_cyc;
    check("b2b_spacing_sb2", a_cur - a_prev, 32'd4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
